// File: rtl/usb_rx_pkt_ctrl.sv
// Packet-level controller behind the USB receiver: classifies packets, filters tokens by address,
// streams data payload with the CRC16 bytes held back, and emits one-cycle events after packet end.
module usb_rx_pkt_ctrl #(
    parameter int MAX_DATA = 64,
    parameter int CNT_W    = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  dev_addr_i,
    input  logic [3:0]  xpid_i,
    input  logic [7:0]  xdata_i,
    input  logic        xpacket_i,
    input  logic        xdatastrobe_i,
    input  logic        xcrc5_ok_i,
    input  logic        xcrc16_ok_i,
    output logic        tok_strobe_o,
    output logic [1:0]  tok_pid_o,
    output logic [3:0]  tok_ep_o,
    output logic        sof_strobe_o,
    output logic [10:0] sof_frame_o,
    output logic        rx_valid_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_data1_o,
    output logic        rx_end_o,
    output logic        rx_ok_o,
    output logic        hs_strobe_o,
    output logic [1:0]  hs_pid_o
);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [CNT_W-1:0] N_TWO = CNT_W'(2);
    localparam logic [CNT_W-1:0] N_OVL = CNT_W'(MAX_DATA + 2);
    localparam logic [CNT_W-1:0] N_SAT = CNT_W'(MAX_DATA + 3);

    typedef enum logic [2:0] {S_IDLE, S_TOKEN, S_DATA, S_HSHAKE, S_DISCARD} state_t;

    state_t           state_q, state_d;
    logic             xpacket_q;
    logic [CNT_W-1:0] n_q, n_d;
    logic [3:0]       pid_q, pid_d;
    logic [7:0]       b0_q, b0_d;
    logic [2:0]       b1_q, b1_d;
    logic [7:0]       dly0_q, dly0_d, dly1_q, dly1_d;
    logic             ovl_q, ovl_d;
    logic             armed_q, armed_d;

    logic        tok_strobe_q, tok_strobe_d, sof_strobe_q, sof_strobe_d;
    logic [1:0]  tok_pid_q, tok_pid_d, hs_pid_q, hs_pid_d;
    logic [3:0]  tok_ep_q, tok_ep_d;
    logic [10:0] sof_frame_q, sof_frame_d;
    logic        rx_valid_q, rx_valid_d, rx_data1_q, rx_data1_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_end_q, rx_end_d, rx_ok_q, rx_ok_d, hs_strobe_q, hs_strobe_d;

    logic start_w, end_w, strobe_w, open_w, tok_valid_w;

    assign start_w  = xpacket_i & ~xpacket_q;
    assign end_w    = xpacket_q & ~xpacket_i;
    assign open_w   = start_w & (state_q == S_IDLE);
    assign strobe_w = xdatastrobe_i & (state_q != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (end_w) begin
            state_d = S_IDLE;
        end else if (open_w) begin
            case (xpid_i)
                PID_OUT, PID_IN, PID_SOF, PID_SETUP: state_d = S_TOKEN;
                PID_DATA0, PID_DATA1:                state_d = armed_q ? S_DATA : S_DISCARD;
                PID_ACK, PID_NAK, PID_STALL:         state_d = S_HSHAKE;
                default:                             state_d = S_DISCARD;
            endcase
        end
    end

    always_comb begin
        n_d = n_q;
        if (open_w)                        n_d = '0;
        else if (strobe_w && n_q != N_SAT) n_d = n_q + CNT_W'(1);
    end

    always_comb begin
        pid_d        = pid_q;
        b0_d         = b0_q;
        b1_d         = b1_q;
        dly0_d       = dly0_q;
        dly1_d       = dly1_q;
        ovl_d        = ovl_q;
        armed_d      = armed_q;
        tok_strobe_d = 1'b0;
        sof_strobe_d = 1'b0;
        rx_valid_d   = 1'b0;
        rx_end_d     = 1'b0;
        rx_ok_d      = 1'b0;
        hs_strobe_d  = 1'b0;
        tok_pid_d    = tok_pid_q;
        tok_ep_d     = tok_ep_q;
        sof_frame_d  = sof_frame_q;
        rx_data_d    = rx_data_q;
        rx_data1_d   = rx_data1_q;
        hs_pid_d     = hs_pid_q;
        tok_valid_w  = 1'b0;

        if (open_w) begin
            pid_d = xpid_i;
            ovl_d = 1'b0;
            if ((xpid_i == PID_DATA0 || xpid_i == PID_DATA1) && armed_q)
                rx_data1_d = xpid_i[3];
        end

        if (strobe_w) begin
            if (state_q == S_TOKEN) begin
                if (n_q == CNT_W'(0)) b0_d = xdata_i;
                if (n_q == CNT_W'(1)) b1_d = xdata_i[2:0];
            end else if (state_q == S_DATA) begin
                // Two-byte delay line keeps the trailing CRC16 bytes off rx_data.
                if (n_q >= N_TWO && n_q < N_OVL) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = dly1_q;
                end
                if (n_q >= N_OVL) ovl_d = 1'b1;
                dly1_d = dly0_q;
                dly0_d = xdata_i;
            end
        end

        // End evaluation uses the _d view so a byte arriving in the end cycle counts.
        if (end_w) begin
            case (state_q)
                S_TOKEN: begin
                    armed_d     = 1'b0;
                    tok_valid_w = (n_d == N_TWO) && xcrc5_ok_i;
                    if (tok_valid_w && pid_q == PID_SOF) begin
                        sof_strobe_d = 1'b1;
                        sof_frame_d  = {b1_d, b0_d};
                    end else if (tok_valid_w && b0_d[6:0] == dev_addr_i) begin
                        tok_strobe_d = 1'b1;
                        tok_ep_d     = {b1_d, b0_d[7]};
                        case (pid_q)
                            PID_OUT: tok_pid_d = 2'b00;
                            PID_IN:  tok_pid_d = 2'b01;
                            default: tok_pid_d = 2'b11;
                        endcase
                        armed_d = (pid_q != PID_IN);
                    end
                end
                S_DATA: begin
                    rx_end_d = 1'b1;
                    rx_ok_d  = xcrc16_ok_i && (n_d >= N_TWO) && !ovl_d;
                    armed_d  = 1'b0;
                end
                S_HSHAKE: begin
                    armed_d = 1'b0;
                    if (n_d == CNT_W'(0)) begin
                        hs_strobe_d = 1'b1;
                        case (pid_q)
                            PID_ACK: hs_pid_d = 2'b00;
                            PID_NAK: hs_pid_d = 2'b01;
                            default: hs_pid_d = 2'b10;
                        endcase
                    end
                end
                S_DISCARD: armed_d = 1'b0;
                default: ;
            endcase
        end
    end

    // xpacket_q resets high so a packet already in flight at reset release is not seen as a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xpacket_q    <= 1'b1;
            n_q          <= '0;
            pid_q        <= '0;
            b0_q         <= '0;
            b1_q         <= '0;
            dly0_q       <= '0;
            dly1_q       <= '0;
            ovl_q        <= 1'b0;
            armed_q      <= 1'b0;
            tok_strobe_q <= 1'b0;
            tok_pid_q    <= '0;
            tok_ep_q     <= '0;
            sof_strobe_q <= 1'b0;
            sof_frame_q  <= '0;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_data1_q   <= 1'b0;
            rx_end_q     <= 1'b0;
            rx_ok_q      <= 1'b0;
            hs_strobe_q  <= 1'b0;
            hs_pid_q     <= '0;
        end else begin
            xpacket_q    <= xpacket_i;
            n_q          <= n_d;
            pid_q        <= pid_d;
            b0_q         <= b0_d;
            b1_q         <= b1_d;
            dly0_q       <= dly0_d;
            dly1_q       <= dly1_d;
            ovl_q        <= ovl_d;
            armed_q      <= armed_d;
            tok_strobe_q <= tok_strobe_d;
            tok_pid_q    <= tok_pid_d;
            tok_ep_q     <= tok_ep_d;
            sof_strobe_q <= sof_strobe_d;
            sof_frame_q  <= sof_frame_d;
            rx_valid_q   <= rx_valid_d;
            rx_data_q    <= rx_data_d;
            rx_data1_q   <= rx_data1_d;
            rx_end_q     <= rx_end_d;
            rx_ok_q      <= rx_ok_d;
            hs_strobe_q  <= hs_strobe_d;
            hs_pid_q     <= hs_pid_d;
        end
    end

    assign tok_strobe_o = tok_strobe_q;
    assign tok_pid_o    = tok_pid_q;
    assign tok_ep_o     = tok_ep_q;
    assign sof_strobe_o = sof_strobe_q;
    assign sof_frame_o  = sof_frame_q;
    assign rx_valid_o   = rx_valid_q;
    assign rx_data_o    = rx_data_q;
    assign rx_data1_o   = rx_data1_q;
    assign rx_end_o     = rx_end_q;
    assign rx_ok_o      = rx_ok_q;
    assign hs_strobe_o  = hs_strobe_q;
    assign hs_pid_o     = hs_pid_q;

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Bench for usb_rx_pkt_ctrl: directed and random packets compared against a packet-level event model.
module tb_usb_rx_pkt_ctrl;

    localparam int MAX_DATA = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  dev_addr = 7'd5;
    logic [3:0]  xpid = 4'd0;
    logic [7:0]  xdata = 8'd0;
    logic        xpacket = 1'b0, xdatastrobe = 1'b0, xcrc5_ok = 1'b0, xcrc16_ok = 1'b0;
    logic        tok_strobe, sof_strobe, rx_valid, rx_data1, rx_end, rx_ok, hs_strobe;
    logic [1:0]  tok_pid, hs_pid;
    logic [3:0]  tok_ep;
    logic [10:0] sof_frame;
    logic [7:0]  rx_data;

    usb_rx_pkt_ctrl #(.MAX_DATA(MAX_DATA), .CNT_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .dev_addr_i(dev_addr), .xpid_i(xpid), .xdata_i(xdata),
        .xpacket_i(xpacket), .xdatastrobe_i(xdatastrobe), .xcrc5_ok_i(xcrc5_ok),
        .xcrc16_ok_i(xcrc16_ok), .tok_strobe_o(tok_strobe), .tok_pid_o(tok_pid),
        .tok_ep_o(tok_ep), .sof_strobe_o(sof_strobe), .sof_frame_o(sof_frame),
        .rx_valid_o(rx_valid), .rx_data_o(rx_data), .rx_data1_o(rx_data1),
        .rx_end_o(rx_end), .rx_ok_o(rx_ok), .hs_strobe_o(hs_strobe), .hs_pid_o(hs_pid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; logic [15:0] v; } ev_t;
    ev_t q_tok[$], q_sof[$], q_rx[$], q_end[$], q_hs[$];

    always @(negedge clk) begin
        ev_t e;
        e.c = cyc;
        if (tok_strobe) begin e.v = {10'd0, tok_pid, tok_ep}; q_tok.push_back(e); end
        if (sof_strobe) begin e.v = {5'd0, sof_frame};        q_sof.push_back(e); end
        if (rx_valid)   begin e.v = {8'd0, rx_data};          q_rx.push_back(e);  end
        if (rx_end)     begin e.v = {14'd0, rx_ok, rx_data1}; q_end.push_back(e); end
        if (hs_strobe)  begin e.v = {14'd0, hs_pid};          q_hs.push_back(e);  end
    end

    int n_checks = 0, n_pass = 0;
    logic [7:0] pkt_bytes [0:79];
    int strobe_cyc [0:79];
    int end_cyc;
    logic armed_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear_q();
        q_tok.delete(); q_sof.delete(); q_rx.delete(); q_end.delete(); q_hs.delete();
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) pkt_bytes[i] = 8'($urandom);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, ".tok_strobe"}, 32'(tok_strobe), 0); chk({nm, ".tok_pid"}, 32'(tok_pid), 0);
        chk({nm, ".tok_ep"}, 32'(tok_ep), 0);         chk({nm, ".sof_strobe"}, 32'(sof_strobe), 0);
        chk({nm, ".sof_frame"}, 32'(sof_frame), 0);   chk({nm, ".rx_valid"}, 32'(rx_valid), 0);
        chk({nm, ".rx_data"}, 32'(rx_data), 0);       chk({nm, ".rx_data1"}, 32'(rx_data1), 0);
        chk({nm, ".rx_end"}, 32'(rx_end), 0);         chk({nm, ".rx_ok"}, 32'(rx_ok), 0);
        chk({nm, ".hs_strobe"}, 32'(hs_strobe), 0);   chk({nm, ".hs_pid"}, 32'(hs_pid), 0);
    endtask

    task automatic send_pkt(input logic [3:0] pid, input int n, input logic c5, input logic c16,
                            input bit sim_end);
        @(posedge clk); #1;
        xpacket = 1'b1; xpid = pid;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            xdatastrobe = 1'b1; xdata = pkt_bytes[i];
            xcrc5_ok  = (i == n - 1) ? c5  : 1'($urandom_range(0, 1));
            xcrc16_ok = (i == n - 1) ? c16 : 1'($urandom_range(0, 1));
            strobe_cyc[i] = cyc;
            if (sim_end && i == n - 1) begin xpacket = 1'b0; end_cyc = cyc; end
            @(posedge clk); #1;
            xdatastrobe = 1'b0;
        end
        if (!(sim_end && n > 0)) begin
            if (n == 0) begin xcrc5_ok = c5; xcrc16_ok = c16; end
            @(posedge clk); #1;
            xpacket = 1'b0; end_cyc = cyc;
        end
        repeat (3) @(posedge clk);
        #1 xpid = 4'($urandom);
    endtask

    // Packet-level expectations derived from PID class, byte count, CRC flags and armed state.
    task automatic check_pkt(input string nm, input logic [3:0] pid, input int n,
                             input logic c5, input logic c16);
        int e_tok = 0, e_sof = 0, e_rx = 0, e_end = 0, e_hs = 0;
        logic [15:0] v_tok = 0, v_sof = 0, v_end = 0, v_hs = 0;
        logic [1:0] tp;
        logic valid, next_armed;
        next_armed = 1'b0;
        case (pid)
            4'b0001, 4'b1001, 4'b1101, 4'b0101: begin
                valid = (n == 2) && c5;
                if (pid == 4'b0101) begin
                    if (valid) begin e_sof = 1; v_sof = {5'd0, pkt_bytes[1][2:0], pkt_bytes[0]}; end
                end else if (valid && pkt_bytes[0][6:0] == dev_addr) begin
                    tp = (pid == 4'b0001) ? 2'b00 : (pid == 4'b1001) ? 2'b01 : 2'b11;
                    e_tok = 1;
                    v_tok = {10'd0, tp, pkt_bytes[1][2:0], pkt_bytes[0][7]};
                    next_armed = (pid != 4'b1001);
                end
            end
            4'b0011, 4'b1011: if (armed_m) begin
                e_end = 1;
                e_rx = ((n < MAX_DATA + 2) ? n : MAX_DATA + 2) - 2;
                if (e_rx < 0) e_rx = 0;
                v_end = {14'd0, c16 && n >= 2 && n <= MAX_DATA + 2, pid[3]};
            end
            4'b0010, 4'b1010, 4'b1110: if (n == 0) begin
                e_hs = 1;
                v_hs = (pid == 4'b0010) ? 16'd0 : (pid == 4'b1010) ? 16'd1 : 16'd2;
            end
            default: ;
        endcase
        armed_m = next_armed;
        chk({nm, ".tok_cnt"}, q_tok.size(), e_tok);
        chk({nm, ".sof_cnt"}, q_sof.size(), e_sof);
        chk({nm, ".rx_cnt"},  q_rx.size(),  e_rx);
        chk({nm, ".end_cnt"}, q_end.size(), e_end);
        chk({nm, ".hs_cnt"},  q_hs.size(),  e_hs);
        if (e_tok > 0 && q_tok.size() > 0) begin
            chk({nm, ".tok_val"}, q_tok[0].v, v_tok); chk({nm, ".tok_cyc"}, q_tok[0].c, end_cyc + 1);
        end
        if (e_sof > 0 && q_sof.size() > 0) begin
            chk({nm, ".sof_val"}, q_sof[0].v, v_sof); chk({nm, ".sof_cyc"}, q_sof[0].c, end_cyc + 1);
        end
        if (e_end > 0 && q_end.size() > 0) begin
            chk({nm, ".end_val"}, q_end[0].v, v_end); chk({nm, ".end_cyc"}, q_end[0].c, end_cyc + 1);
        end
        if (e_hs > 0 && q_hs.size() > 0) begin
            chk({nm, ".hs_val"}, q_hs[0].v, v_hs); chk({nm, ".hs_cyc"}, q_hs[0].c, end_cyc + 1);
        end
        for (int i = 0; i < e_rx && i < q_rx.size(); i++) begin
            chk($sformatf("%s.rx_data[%0d]", nm, i), q_rx[i].v, {8'd0, pkt_bytes[i]});
            chk($sformatf("%s.rx_cyc[%0d]", nm, i), q_rx[i].c, strobe_cyc[i + 2] + 1);
        end
        clear_q();
    endtask

    task automatic pkt(input string nm, input logic [3:0] pid, input int n, input logic c5,
                       input logic c16, input bit sim_end);
        send_pkt(pid, n, c5, c16, sim_end);
        check_pkt(nm, pid, n, c5, c16);
        $display("pkt %s pid=%b n=%0d c5=%0b c16=%0b sim_end=%0b", nm, pid, n, c5, c16, sim_end);
    endtask

    task automatic out_tok(input string nm);
        pkt_bytes[0] = {1'b0, dev_addr}; pkt_bytes[1] = 8'h00;
        pkt(nm, 4'b0001, 2, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        logic [3:0] pid;
        int n, r;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        clear_q();

        pkt_bytes[0] = 8'h05; pkt_bytes[1] = 8'hE8;
        pkt("setup", 4'b1101, 2, 1'b1, 1'b1, 1'b0);
        chk("setup.tok_pid_held", 32'(tok_pid), 32'h3);
        chk("setup.tok_ep_held", 32'(tok_ep), 32'h0);

        pkt_bytes[0] = 8'h03; pkt_bytes[1] = 8'h01;
        pkt("in_other_addr", 4'b1001, 2, 1'b1, 1'b1, 1'b0);
        pkt_bytes[0] = 8'hFF; pkt_bytes[1] = 8'h03;
        pkt("sof", 4'b0101, 2, 1'b1, 1'b1, 1'b1);
        chk("sof.frame_held", 32'(sof_frame), 32'h3FF);

        out_tok("out1");
        pkt_bytes[0] = 8'h11; pkt_bytes[1] = 8'h22; pkt_bytes[2] = 8'h33;
        pkt_bytes[3] = 8'hC1; pkt_bytes[4] = 8'hC2;
        pkt("data1", 4'b1011, 5, 1'b1, 1'b1, 1'b0);
        chk("data1.rx_data1_held", 32'(rx_data1), 32'h1);

        fill_rand(6);
        pkt("data0_unarmed", 4'b0011, 6, 1'b1, 1'b1, 1'b0);
        pkt_bytes[0] = 8'h05; pkt_bytes[1] = 8'h00;
        pkt("in_match", 4'b1001, 2, 1'b1, 1'b1, 1'b0);
        fill_rand(6);
        pkt("data0_after_in", 4'b0011, 6, 1'b1, 1'b1, 1'b0);

        out_tok("out2"); fill_rand(MAX_DATA + 3);
        pkt("data_overlen", 4'b0011, MAX_DATA + 3, 1'b1, 1'b1, 1'b0);
        out_tok("out3"); fill_rand(MAX_DATA + 2);
        pkt("data_maxlen", 4'b0011, MAX_DATA + 2, 1'b1, 1'b1, 1'b1);
        out_tok("out4"); fill_rand(10);
        pkt("data_badcrc", 4'b1011, 10, 1'b1, 1'b0, 1'b0);
        out_tok("out5"); fill_rand(1);
        pkt("data_short", 4'b0011, 1, 1'b1, 1'b1, 1'b0);

        pkt("nak", 4'b1010, 0, 1'b1, 1'b1, 1'b0);
        chk("nak.hs_pid_held", 32'(hs_pid), 32'h1);

        out_tok("out6");
        @(posedge clk); #1 xpacket = 1'b1; xpid = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 xdatastrobe = 1'b1; xdata = 8'($urandom);
            @(posedge clk); #1 xdatastrobe = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("rst_mid");
        @(posedge clk); #1 rst_n = 1'b1;
        clear_q();
        armed_m = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1 xdatastrobe = 1'b1; xdata = 8'($urandom);
            @(posedge clk); #1 xdatastrobe = 1'b0;
        end
        @(posedge clk); #1 xpacket = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid.end_cnt", q_end.size(), 0);
        chk("rst_mid.rx_cnt", q_rx.size(), 0);
        clear_q();
        fill_rand(4);
        pkt("post_rst_unarmed", 4'b0011, 4, 1'b1, 1'b1, 1'b0);
        out_tok("out7"); fill_rand(4);
        pkt("post_rst_data1", 4'b1011, 4, 1'b1, 1'b1, 1'b0);

        dev_addr = 7'($urandom_range(1, 127));
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1: pid = 4'b0001;
                2:    pid = 4'b1101;
                3:    pid = 4'b1001;
                4:    pid = 4'b0101;
                5, 6: pid = 4'b0011;
                7:    pid = 4'b1011;
                8:    pid = ($urandom_range(0, 2) == 0) ? 4'b0010 : (($urandom_range(0, 1) == 0) ? 4'b1010 : 4'b1110);
                default: pid = 4'($urandom);
            endcase
            if (pid[1:0] == 2'b01)
                n = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : 2;
            else if (pid[1:0] == 2'b11)
                n = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 12);
            else
                n = ($urandom_range(0, 3) == 0) ? 1 : 0;
            fill_rand(n);
            if ($urandom_range(0, 9) < 7) pkt_bytes[0][6:0] = dev_addr;
            pkt($sformatf("rnd%0d", it), pid, n, $urandom_range(0, 9) != 0,
                $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
